// File: rtl/instr_decode.sv
// MIPS decode stage with register file, load-use interlock and valid/ready handshake.
// Optional feature: DECODE_ILLEGAL_TRAP_EN traps unsupported encodings.
module instr_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  shamt,
    output logic [31:0] SRC,
    output logic [31:0] TARG,
    output logic [31:0] immediateVal,
    output logic [31:0] pc,
    output logic [31:0] inpc
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    logic [31:0] rf_q [32];

    logic        valid_q, valid_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [5:0]  funct_q, funct_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [4:0]  rt_q, rt_d;
    logic [31:0] src_q, src_d;
    logic [31:0] targ_q, targ_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inpc_q, inpc_d;

    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [31:0] pc4;
    logic [31:0] src_rd, targ_rd;
    logic        stall, xfer, rt_used;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    logic legal;

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: legal = in_instr[5:0] inside
                {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                 6'b100110, 6'b101010, 6'b000000, 6'b000010};
            OP_J, OP_ADDI, OP_ANDI, OP_LW,
            OP_SW, OP_BEQ, OP_BNE: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign illegal = illegal_q;
`endif

    always_comb begin
        op  = in_instr[31:26];
        rs  = in_instr[25:21];
        rt  = in_instr[20:16];
        pc4 = in_pc + 32'd4;

        // Same-cycle write-back is bypassed onto the read ports
        if (rs == 5'd0)                       src_rd = 32'd0;
        else if (wb_en && (wb_addr == rs))    src_rd = wb_data;
        else                                  src_rd = rf_q[rs];

        if (rt == 5'd0)                       targ_rd = 32'd0;
        else if (wb_en && (wb_addr == rt))    targ_rd = wb_data;
        else                                  targ_rd = rf_q[rt];

        rt_used = op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
        stall   = valid_q && (opcode_q == OP_LW) && (rt_q != 5'd0)
                  && in_valid
                  && ((rs == rt_q) || (rt_used && (rt == rt_q)));

        in_ready = !rst && (!valid_q || out_ready) && !stall;
        xfer     = in_valid && in_ready;

        valid_d  = valid_q && !out_ready;
        opcode_d = opcode_q;
        funct_d  = funct_q;
        shamt_d  = shamt_q;
        rt_d     = rt_q;
        src_d    = src_q;
        targ_d   = targ_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        inpc_d   = inpc_q;

        if (xfer) begin
            valid_d  = 1'b1;
            opcode_d = op;
            funct_d  = in_instr[5:0];
            shamt_d  = in_instr[10:6];
            rt_d     = rt;
            src_d    = src_rd;
            targ_d   = targ_rd;
            imm_d    = (op == OP_ANDI) ? {16'd0, in_instr[15:0]}
                                       : {{16{in_instr[15]}}, in_instr[15:0]};
            pc_d     = pc4;
            inpc_d   = {pc4[31:28], in_instr[25:0], 2'b00};
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal_d = xfer && !legal;
        if (xfer && !legal) valid_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (wb_en && (wb_addr != 5'd0)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            opcode_q <= 6'd0;
            funct_q  <= 6'd0;
            shamt_q  <= 5'd0;
            rt_q     <= 5'd0;
            src_q    <= 32'd0;
            targ_q   <= 32'd0;
            imm_q    <= 32'd0;
            pc_q     <= 32'd0;
            inpc_q   <= 32'd0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            funct_q  <= funct_d;
            shamt_q  <= shamt_d;
            rt_q     <= rt_d;
            src_q    <= src_d;
            targ_q   <= targ_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            inpc_q   <= inpc_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign out_valid    = valid_q;
    assign opcode       = opcode_q;
    assign funct        = funct_q;
    assign shamt        = shamt_q;
    assign SRC          = src_q;
    assign TARG         = targ_q;
    assign immediateVal = imm_q;
    assign pc           = pc_q;
    assign inpc         = inpc_q;

endmodule

// File: tb/tb_instr_decode.sv
// Directed table-driven bench for instr_decode.
// Checks the trap path when DECODE_ILLEGAL_TRAP_EN is defined.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] SRC;
    logic [31:0] TARG;
    logic [31:0] immediateVal;
    logic [31:0] pc;
    logic [31:0] inpc;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int checks = 0;
    int failures = 0;

    instr_decode dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .funct(funct), .shamt(shamt),
        .SRC(SRC), .TARG(TARG), .immediateVal(immediateVal),
        .pc(pc), .inpc(inpc)
`ifdef DECODE_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcin;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [31:0] src;
        logic [31:0] targ;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] inpc;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] p);
        in_instr = w;
        in_pc    = p;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    initial begin
        vt[0] = '{32'h00221820, 32'h00400000, 6'h00, 6'h20, 5'd0,
                  32'd5, 32'd7, 32'h00001820, 32'h00400004, 32'h00886080};
        vt[1] = '{32'h2023FFFF, 32'h00400010, 6'h08, 6'h3F, 5'd31,
                  32'd5, 32'd0, 32'hFFFFFFFF, 32'h00400014, 32'h008FFFFC};
        vt[2] = '{32'h3043FFFF, 32'h00400020, 6'h0C, 6'h3F, 5'd31,
                  32'd7, 32'd0, 32'h0000FFFF, 32'h00400024, 32'h010FFFFC};
        vt[3] = '{32'h00021900, 32'hF0000000, 6'h00, 6'h00, 5'd4,
                  32'd0, 32'd7, 32'h00001900, 32'hF0000004, 32'hF0086400};
        vt[4] = '{32'h08100000, 32'h7FFFFFFC, 6'h02, 6'h00, 5'd0,
                  32'd0, 32'd0, 32'h00000000, 32'h80000000, 32'h80400000};
        vt[5] = '{32'hAC22FFFC, 32'h00000000, 6'h2B, 6'h3C, 5'd31,
                  32'd5, 32'd7, 32'hFFFFFFFC, 32'h00000004, 32'h008BFFF0};
        vt[6] = '{32'h10228000, 32'h00000000, 6'h04, 6'h00, 5'd0,
                  32'd5, 32'd7, 32'hFFFF8000, 32'h00000004, 32'h008A0000};
        vt[7] = '{32'h20217FFF, 32'h00000000, 6'h08, 6'h3F, 5'd31,
                  32'd5, 32'd5, 32'h00007FFF, 32'h00000004, 32'h0085FFFC};

        rst = 1'b1;
        in_valid = 1'b0;
        in_instr = 32'd0;
        in_pc = 32'd0;
        wb_en = 1'b0;
        wb_addr = 5'd0;
        wb_data = 32'd0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_src", SRC, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_inpc", inpc, 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("rst_illegal", 32'(illegal), 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        wb(5'd1, 32'd5);
        wb(5'd2, 32'd7);

        for (int i = 0; i < 8; i++) begin
            in_instr = vt[i].instr;
            in_pc    = vt[i].pcin;
            in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_opcode", i), 32'(opcode), 32'(vt[i].op));
            chk($sformatf("v%0d_funct", i), 32'(funct), 32'(vt[i].fn));
            chk($sformatf("v%0d_shamt", i), 32'(shamt), 32'(vt[i].sh));
            chk($sformatf("v%0d_src", i), SRC, vt[i].src);
            chk($sformatf("v%0d_targ", i), TARG, vt[i].targ);
            chk($sformatf("v%0d_imm", i), immediateVal, vt[i].imm);
            chk($sformatf("v%0d_pc", i), pc, vt[i].pc);
            chk($sformatf("v%0d_inpc", i), inpc, vt[i].inpc);
            step();
            chk($sformatf("v%0d_bubble", i), 32'(out_valid), 32'd0);
        end

        // lw r4,0(r1) then add r5,r4,r2: one bubble
        send(32'h8C240000, 32'h0);
        in_instr = 32'h00822820;
        in_valid = 1'b1;
        #1;
        chk("lu_stall_ready", 32'(in_ready), 32'd0);
        chk("lu_lw_opcode", 32'(opcode), 32'h23);
        step();
        chk("lu_bubble", 32'(out_valid), 32'd0);
        #1;
        chk("lu_ready_again", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("lu_add_valid", 32'(out_valid), 32'd1);
        chk("lu_add_funct", 32'(funct), 32'h20);
        chk("lu_add_targ", TARG, 32'd7);
        step();

        // addi writes rt: no interlock
        send(32'h8C240000, 32'h0);
        in_instr = 32'h20240001;
        in_valid = 1'b1;
        #1;
        chk("lu_addi_nostall", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("lu_addi_imm", immediateVal, 32'd1);
        step();

        // sw reads the lw target as rt: interlock
        send(32'h8C240000, 32'h0);
        in_instr = 32'hAC240000;
        in_valid = 1'b1;
        #1;
        chk("lu_sw_stall", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        step();
        step();

        // write-back during a stall still lands
        send(32'h8C240000, 32'h0);
        in_instr = 32'h00822820;
        in_valid = 1'b1;
        wb_en = 1'b1;
        wb_addr = 5'd2;
        wb_data = 32'h55;
        #1;
        chk("wbst_stall", 32'(in_ready), 32'd0);
        step();
        wb_en = 1'b0;
        step();
        in_valid = 1'b0;
        chk("wbst_valid", 32'(out_valid), 32'd1);
        chk("wbst_targ", TARG, 32'h55);
        step();
        wb(5'd2, 32'd7);

        // back-pressure: held bundle stays stable
        out_ready = 1'b0;
        send(32'h00221820, 32'h100);
        in_instr = 32'h2023FFFF;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold%0d_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("hold%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d_src", k), SRC, 32'd5);
            chk($sformatf("hold%0d_funct", k), 32'(funct), 32'h20);
            chk($sformatf("hold%0d_pc", k), pc, 32'h104);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("hold_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("hold_next_op", 32'(opcode), 32'h08);
        chk("hold_next_imm", immediateVal, 32'hFFFFFFFF);
        step();

        // write-through and r0
        wb_en = 1'b1;
        wb_addr = 5'd1;
        wb_data = 32'd9;
        send(32'h00221820, 32'h0);
        wb_en = 1'b0;
        chk("wt_src", SRC, 32'd9);
        chk("wt_targ", TARG, 32'd7);
        step();
        wb_en = 1'b1;
        wb_addr = 5'd0;
        wb_data = 32'h1234;
        send(32'h00021820, 32'h0);
        wb_en = 1'b0;
        chk("r0_src_wt", SRC, 32'd0);
        step();
        send(32'h00021820, 32'h0);
        chk("r0_src_after", SRC, 32'd0);
        step();
        send(32'h00221820, 32'h0);
        chk("r1_written", SRC, 32'd9);
        step();

        // reset during a held bundle
        out_ready = 1'b0;
        send(32'h00221820, 32'h0);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(in_ready), 32'd0);
        step();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_src", SRC, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        send(32'h00221820, 32'h0);
        chk("midrst_rf_src", SRC, 32'd0);
        chk("midrst_rf_targ", TARG, 32'd0);
        step();

`ifdef DECODE_ILLEGAL_TRAP_EN
        send(32'hFC000000, 32'h0);
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_no_bundle", 32'(out_valid), 32'd0);
        step();
        chk("ill_clear", 32'(illegal), 32'd0);
        send(32'h0000003F, 32'h0);
        chk("ill_funct_pulse", 32'(illegal), 32'd1);
        chk("ill_funct_valid", 32'(out_valid), 32'd0);
        step();
`else
        send(32'hFC000000, 32'h0);
        chk("unsup_fwd_valid", 32'(out_valid), 32'd1);
        chk("unsup_fwd_op", 32'(opcode), 32'h3F);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
